// File: rtl/hardware_output_encoder_pkg.sv
// Shared definitions for the hardware output encoder: the scan FSM states,
// active-low seven-segment patterns (gfedcba) and the write-select encodings.
package hardware_output_encoder_pkg;

    typedef enum logic {
        ST_ON    = 1'b0,
        ST_BLANK = 1'b1
    } scan_state_e;

    // Active-low segment patterns, bit 0 = a ... bit 6 = g
    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b0000011;
    localparam logic [6:0] SEG_C   = 7'b1000110;
    localparam logic [6:0] SEG_D   = 7'b0100001;
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_F   = 7'b0001110;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // All anodes off for the default four-digit board
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    localparam logic WR_SEL_DISPLAY = 1'b0;
    localparam logic WR_SEL_LED     = 1'b1;

endpackage

// File: rtl/hardware_output_encoder_hex_to_seg.sv
// Hex digit to active-low seven-segment decoder (purely combinational).
// Ports: hex   - 4-bit digit value
//        seg_c - active-low segments, bit 0 = a ... bit 6 = g
module hex_to_seg
    import hardware_output_encoder_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_OFF;
        case (hex)
            4'h0: seg_c = SEG_0;
            4'h1: seg_c = SEG_1;
            4'h2: seg_c = SEG_2;
            4'h3: seg_c = SEG_3;
            4'h4: seg_c = SEG_4;
            4'h5: seg_c = SEG_5;
            4'h6: seg_c = SEG_6;
            4'h7: seg_c = SEG_7;
            4'h8: seg_c = SEG_8;
            4'h9: seg_c = SEG_9;
            4'hA: seg_c = SEG_A;
            4'hB: seg_c = SEG_B;
            4'hC: seg_c = SEG_C;
            4'hD: seg_c = SEG_D;
            4'hE: seg_c = SEG_E;
            4'hF: seg_c = SEG_F;
            default: seg_c = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/hardware_output_encoder.sv
// Output encoder: processor writes drive a multiplexed active-low
// seven-segment display (double-buffered, swapped at frame boundaries)
// and a bank of active-high LEDs.
// Ports: clk, reset_n (async active-low)
//        wr_en/wr_sel/wr_data - write strobe, target select, data
//        display_en           - 0 blanks the anodes, scanning continues
//        wr_ack               - one-cycle pulse after each write
//        seg/anode            - active-low segments and digit enables
//        led                  - LED drive
module hardware_output_encoder
    import hardware_output_encoder_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned LED_W        = 8,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic                  display_en,
    output logic                  wr_ack,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     anode,
    output logic [LED_W-1:0]      led
);

    localparam int unsigned DATA_W  = 4 * DIGITS;
    localparam int unsigned CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned DIG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    scan_state_e         state, state_nxt;
    logic [CNT_W-1:0]    div_cnt, div_nxt;
    logic [DIG_W-1:0]    digit, digit_nxt;
    logic [DATA_W-1:0]   shadow, active, active_nxt;
    logic [DIGITS-1:0]   anode_nxt;
    logic [3:0]          nibble_c;
    logic [6:0]          seg_nxt_c;

    // Segment decode for the digit that will be lit after the next edge
    hex_to_seg u_hex_to_seg (
        .hex   (nibble_c),
        .seg_c (seg_nxt_c)
    );

    // Scan FSM next state, frame-boundary buffer swap and next anode/segment values
    always_comb begin
        state_nxt  = state;
        div_nxt    = div_cnt + CNT_W'(1);
        digit_nxt  = digit;
        active_nxt = active;
        anode_nxt  = '1;
        nibble_c   = 4'h0;

        case (state)
            ST_ON: begin
                if (div_cnt == CNT_W'(SCAN_DIV - 1)) begin
                    state_nxt = ST_BLANK;
                    div_nxt   = '0;
                end
            end
            ST_BLANK: begin
                if (div_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_nxt = ST_ON;
                    div_nxt   = '0;
                    if (digit == DIG_W'(DIGITS - 1)) begin
                        // Frame boundary: take the pre-edge shadow value
                        digit_nxt  = '0;
                        active_nxt = shadow;
                    end else begin
                        digit_nxt = digit + DIG_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_ON;
                div_nxt   = '0;
            end
        endcase

        // Both registers are loaded from next-state values so they stay aligned
        nibble_c = 4'(active_nxt >> {digit_nxt, 2'b00});
        if ((state_nxt == ST_ON) && display_en) begin
            anode_nxt = ~(DIGITS'(1) << digit_nxt);
        end
    end

    // State, buffers and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_ON;
            div_cnt <= '0;
            digit   <= '0;
            shadow  <= '0;
            active  <= '0;
            led     <= '0;
            wr_ack  <= 1'b0;
            anode   <= ~DIGITS'(1);
            seg     <= SEG_0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
            digit   <= digit_nxt;
            active  <= active_nxt;
            anode   <= anode_nxt;
            seg     <= seg_nxt_c;
            wr_ack  <= wr_en;
            if (wr_en && (wr_sel == WR_SEL_DISPLAY)) begin
                shadow <= wr_data;
            end
            if (wr_en && (wr_sel == WR_SEL_LED)) begin
                led <= wr_data[LED_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_hardware_output_encoder.sv
// Directed testbench for hardware_output_encoder with a short scan
// (SCAN_DIV=4, BLANK_CYCLES=1, 20-cycle frames). Time index t counts rising
// edges since reset release; anode is checked on every cycle.
module tb_hardware_output_encoder;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic        wr_sel;
    logic [15:0] wr_data;
    logic        display_en;
    logic        wr_ack;
    logic [6:0]  seg;
    logic [3:0]  anode;
    logic [7:0]  led;

    int checks;
    int errors;
    int t;
    bit de_exp;

    hardware_output_encoder #(
        .DIGITS       (4),
        .LED_W        (8),
        .SCAN_DIV     (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .display_en (display_en),
        .wr_ack     (wr_ack),
        .seg        (seg),
        .anode      (anode),
        .led        (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t, obs, exp_v);
        end
    endtask

    // Frame of 20: slots of 4 lit cycles then 1 blank cycle, digit 0 first
    function automatic logic [3:0] exp_anode(input int tt);
        int p;
        logic [3:0] one;
        p   = tt % 20;
        one = 4'b0001;
        if ((p % 5) == 4) return 4'b1111;
        return ~(one << (p / 5));
    endfunction

    task automatic run_to(input int target);
        while (t < target) begin
            @(posedge clk);
            #1;
            t++;
            chk("anode", 32'(anode), de_exp ? 32'(exp_anode(t)) : 32'hF);
        end
    endtask

    initial begin
        checks = 0; errors = 0; t = 0; de_exp = 1'b1;
        reset_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_data = '0; display_en = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_anode", 32'(anode), 32'hE);
        chk("rst_seg", 32'(seg), 32'h40);
        chk("rst_led", 32'(led), 32'h00);
        chk("rst_ack", 32'(wr_ack), 32'h0);

        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("t0_anode", 32'(anode), 32'hE);
        chk("t0_seg", 32'(seg), 32'h40);

        // Idle frame shows 0 on every digit
        run_to(19); chk("idle_seg_d3", 32'(seg), 32'h40);
        run_to(20); chk("idle_seg_wrap", 32'(seg), 32'h40);

        // Display write mid-frame, applied at the next boundary (t=40)
        run_to(25);
        wr_en = 1'b1; wr_sel = 1'b0; wr_data = 16'h12AF;
        run_to(26); chk("ack_disp", 32'(wr_ack), 32'h1);
        wr_en = 1'b0;
        run_to(27); chk("ack_low", 32'(wr_ack), 32'h0);
        run_to(39); chk("pre_boundary", 32'(seg), 32'h40);
        run_to(40); chk("seg_d0_F", 32'(seg), 32'h0E);
        run_to(44); chk("seg_blank_F", 32'(seg), 32'h0E);
        run_to(45); chk("seg_d1_A", 32'(seg), 32'h08);
        run_to(50); chk("seg_d2_2", 32'(seg), 32'h24);
        run_to(55); chk("seg_d3_1", 32'(seg), 32'h79);

        // LED write
        run_to(57); chk("led_before", 32'(led), 32'h00);
        wr_en = 1'b1; wr_sel = 1'b1; wr_data = 16'hBEA5;
        run_to(58);
        chk("led_A5", 32'(led), 32'hA5);
        chk("ack_led", 32'(wr_ack), 32'h1);
        chk("seg_after_led", 32'(seg), 32'h79);
        wr_en = 1'b0;
        run_to(60); chk("seg_led_nochg", 32'(seg), 32'h0E);

        // Shadow=0001, then a write of 0003 on the boundary edge (t=99->100)
        run_to(82);
        wr_en = 1'b1; wr_sel = 1'b0; wr_data = 16'h0001;
        run_to(83); wr_en = 1'b0;
        run_to(85); chk("old_active_d1", 32'(seg), 32'h08);
        run_to(99);
        wr_en = 1'b1; wr_sel = 1'b0; wr_data = 16'h0003;
        run_to(100);
        chk("ack_bnd", 32'(wr_ack), 32'h1);
        chk("bnd_d0_1", 32'(seg), 32'h79);
        wr_en = 1'b0;
        run_to(105); chk("bnd_d1_0", 32'(seg), 32'h40);
        run_to(115); chk("bnd_d3_0", 32'(seg), 32'h40);
        run_to(120); chk("next_d0_3", 32'(seg), 32'h30);

        // Display disabled for one frame; FSM keeps advancing
        run_to(122);
        display_en = 1'b0; de_exp = 1'b0;
        run_to(142);
        display_en = 1'b1; de_exp = 1'b1;
        run_to(146);

        // Reset mid-BLANK with active=FFFF and an in-flight LED write
        run_to(150);
        wr_en = 1'b1; wr_sel = 1'b0; wr_data = 16'hFFFF;
        run_to(151); wr_en = 1'b0;
        run_to(160); chk("seg_FFFF", 32'(seg), 32'h0E);
        run_to(164);
        chk("led_hold", 32'(led), 32'hA5);
        wr_en = 1'b1; wr_sel = 1'b1; wr_data = 16'h00FF;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_anode", 32'(anode), 32'hE);
        chk("mid_rst_seg", 32'(seg), 32'h40);
        chk("mid_rst_led", 32'(led), 32'h00);
        chk("mid_rst_ack", 32'(wr_ack), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_hold_ack", 32'(wr_ack), 32'h0);
        chk("rst_hold_led", 32'(led), 32'h00);
        wr_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        t = 0;
        #1;
        chk("rel_anode", 32'(anode), 32'hE);
        chk("rel_ack", 32'(wr_ack), 32'h0);
        run_to(4); chk("rel_seg_blank", 32'(seg), 32'h40);
        run_to(5); chk("rel_seg_d1", 32'(seg), 32'h40);
        run_to(20);
        chk("rel_seg_frame", 32'(seg), 32'h40);
        chk("rel_led", 32'(led), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hardware_output_encoder.md
Name: hardware_output_encoder

Overview:
Output-side counterpart of the hardware input decoder. The processor writes 16-bit values into this block, and the block drives the board hardware from them: a 4-digit multiplexed active-low seven-segment display (hex) and 8 LEDs. Display updates are double-buffered and applied only at frame boundaries, so a digit never shows half of one value and half of another. The block sits on the processor's output-port path.

Parameters:
DIGITS, 4, number of seven-segment digits; the data width is 4*DIGITS.
LED_W, 8, number of LEDs.
SCAN_DIV, 50000, clock cycles each digit is lit.
BLANK_CYCLES, 500, all-anodes-off cycles between digits (anti-ghosting); must be ≥1.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
wr_en  input  1  write strobe, one cycle per write
wr_sel  input  1  0 = display value, 1 = LED value
wr_data  input  4*DIGITS  write data; the LED write uses bits [LED_W-1:0]
display_en  input  1  0 = display blanked; scanning continues
wr_ack  output  1  one-cycle pulse, registered, the cycle after an accepted write
seg  output  7  active-low segments, seg[0]=a … seg[6]=g
anode  output  DIGITS  active-low digit enables, anode[0] = rightmost digit
led  output  LED_W  LED drive, active-high

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: shadow=0, active=0, led=0, wr_ack=0, digit=0, state=ON, div_cnt=0, anode=all-ones except bit0 (4'b1110), seg=7'b1000000 (hex 0).
- Reset asserted mid-operation clears all state immediately. An in-flight write is lost and no wr_ack is produced.
- Writes are always accepted; there is no backpressure.
  - wr_en=1, wr_sel=1: led <= wr_data[LED_W-1:0] at the next edge.
  - wr_en=1, wr_sel=0: shadow <= wr_data at the next edge.
  - wr_ack=1 in the cycle after any wr_en=1. Back-to-back writes give back-to-back acks. The last write wins.
- Scan FSM has two states, ON and BLANK, driven by div_cnt (width clog2(max(SCAN_DIV,BLANK_CYCLES))).
  - ON: anode = one-hot-low at digit (forced all-ones if display_en=0). div_cnt increments each cycle. When div_cnt==SCAN_DIV-1: state<=BLANK, div_cnt<=0.
  - BLANK: anode = all-ones. div_cnt increments. When div_cnt==BLANK_CYCLES-1: state<=ON, div_cnt<=0, digit<=(digit+1) mod DIGITS.
  - Frame boundary: the BLANK->ON edge where digit wraps DIGITS-1 -> 0. On that edge, active<=shadow.
  - A display write in the same cycle as a frame boundary: the boundary copies the pre-edge shadow. The new value is applied at the following boundary, one full frame later.
  - Frame length = DIGITS*(SCAN_DIV+BLANK_CYCLES) cycles.
- Segment output:
  - seg = hex7(active[4*digit+3 : 4*digit]), registered so it is aligned with anode.
  - Segments remain driven while blanked; anodes alone blank the display.
- hex7 (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- display_en changes take effect on anode in the next cycle. The FSM and the frame-boundary copy are unaffected by display_en.
- LEDs have no buffering and are unaffected by scanning.

Decomposition:
- Shared package: scan state enum {ST_ON, ST_BLANK}, the hex7 segment constants SEG_0..SEG_F, SEG_OFF=7'b1111111, ANODE_OFF, and the WR_SEL_DISPLAY/WR_SEL_LED encodings.
- One combinational sub-module, hex_to_seg (4-bit in, 7-bit active-low out), instantiated once.

Test Plan:
- Reset, then SCAN_DIV=4, BLANK_CYCLES=1, no writes -> seg=1000000 on every digit; anode sequence 1110 ×4, 1111 ×1, 1101 ×4, 1111, 1011…; frame = 20 cycles.
- Display write wr_data=16'h12AF mid-frame -> wr_ack pulses the next cycle; the display keeps showing 0000 until the frame boundary; the next frame shows digit0=0001110 (F), digit1=0001000 (A), digit2=0100100 (2), digit3=1111001 (1).
- LED write wr_sel=1, wr_data=16'hBEA5 -> led=8'hA5 on the next edge; the display is unchanged.
- Display write 16'h0003 coinciding with the frame-boundary edge, while shadow holds 16'h0001 -> the next frame shows 0001; the frame after that shows 0003.
- display_en=0 for one frame -> anode=1111 throughout and the FSM keeps advancing; re-enabling lights the digit that the FSM has reached, with no restart.
- Assert reset_n=0 mid-BLANK with active=16'hFFFF -> the same cycle gives anode=1110, seg=1000000, led=0; after release, scanning starts from digit 0, ON, div_cnt=0.
